inv_round_engine: RTL and testbench
===================================

Name: inv_round_engine

Overview:
- Iterative decryption engine for the modified AES-128 cipher round. It applies the exact inverse of the modified forward round once per round, for NR rounds, in descending round order.
- It holds a local round-key store, loaded by the key-schedule side before decryption starts. This lets the block run without inverting the key generator.
- Sits beside the forward round datapath. It takes a ciphertext block and returns the plaintext through a start/done handshake.

Parameters:
NR, 10, number of modified rounds to invert (1..16)
KA_W, 6, key-store address width; must satisfy 2^KA_W >= 3*NR

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
KEY_WR_EN  input  1  key-store write strobe
KEY_WR_ADDR  input  KA_W  key-store entry index = 3*(r-1)+j; r = round 1..NR; j=0: first subkey, j=1: second, j=2: third
KEY_WR_DATA  input  128  subkey value
START  input  1  begin decryption of IN_DATA; sampled only in IDLE
IN_DATA  input  128  ciphertext block; sampled with START
BUSY  output  1  high while decrypting
DONE  output  1  one-cycle pulse, OUT_DATA valid
OUT_DATA  output  128  plaintext; holds until the next DONE or reset

Behaviour:
- Forward round definition, used as the golden reference:
  - sb = SubBytes(d); x = sb ^ k0; s = ShiftRows(x)
  - m = per-byte add mod 2^8 of s and k1; c = MixColumns(m); out = c ^ k2
- Inverse round is computed in 3 phases, one per clock:
  - P0: st <= InvMixColumns(st ^ k2)
  - P1: st <= InvShiftRows(per-byte (st - k1) mod 2^8); each byte wraps independently, no borrow crosses bytes
  - P2: st <= InvSubBytes(st ^ k0)
- Key store: 3*NR x 128-bit registers, combinational read, all entries reset to 0.
  - A write takes effect at the clock edge where KEY_WR_EN=1, BUSY=0 and KEY_WR_ADDR < 3*NR.
  - Writes while BUSY=1 are ignored.
  - Writes to out-of-range addresses are ignored.
- FSM states are IDLE, RUN and FIN. Internal state: phase counter (0..2) and round counter rnd.
  - IDLE:
    - If START=1: st <= IN_DATA, rnd <= NR, phase <= 0, BUSY <= 1, then go to RUN.
    - If START=0: stay in IDLE.
  - RUN: perform the current phase using keys at 3*(rnd-1)+{0,1,2}.
    - After P2 with rnd > 1: rnd <= rnd-1, phase <= 0.
    - After P2 with rnd == 1: OUT_DATA <= result, then go to FIN.
  - FIN: DONE=1 for exactly this one cycle, BUSY=0, then go to IDLE.
- Latency: START sampled at edge 0. Phases occupy edges 1..3*NR. DONE is high in the cycle after edge 3*NR, which is 30 cycles for NR=10. Back-to-back START is allowed in the FIN cycle's following IDLE.
- START during RUN or FIN is ignored; it is not queued.
- START and KEY_WR_EN together in IDLE: the write lands at the same edge, so the run uses the new key.
- No special final round: all NR rounds are identical inverse rounds. Any whitening key is applied outside this block.
- Reset (asynchronous, at any time, including mid-run):
  - BUSY=0, DONE=0, OUT_DATA=0, st=0, FSM goes to IDLE.
  - All key-store entries are cleared to 0.
  - No partial result ever appears on OUT_DATA.
- Byte order: byte 0 = bits [127:120]. Column-major state, as in the forward datapath.

Test Plan:
1. Reset → BUSY=0, DONE=0, OUT_DATA=0. After release with no activity, outputs stay 0 for 20 cycles.
2. NR=1, no key writes (all keys 0), IN_DATA=0, START → DONE after 3 cycles, OUT_DATA=128'h52525252_52525252_52525252_52525252.
3. Mod-subtract wrap: NR=1, addr1 written 128'h0101...01, others 0, IN_DATA=0 → OUT_DATA=128'h7d7d...7d (0x00-0x01=0xFF, InvS(0xFF)=0x7D).
4. Round trip: NR=10, load 30 subkeys from the golden forward schedule, encrypt 128'h00112233_44556677_8899aabb_ccddeeff with the golden forward model, feed the ciphertext → OUT_DATA equals the plaintext, DONE exactly 30 cycles after START, BUSY high for cycles 1..30.
5. Blocking: during a run, pulse START with a different block and write addr 0 → the result is unchanged versus the undisturbed run, exactly one DONE occurs, and key 0 keeps its old value on the next run.
6. Mid-run reset at cycle 12 → immediately BUSY=0, OUT_DATA=0. A later START with the same IN_DATA matches scenario 2 behaviour for zero keys (NR=1 build) with no stale state.

Source files
------------

// File: rtl/inv_round_engine.sv
// Iterative inverse of the modified AES-128 round: three phases per round,
// NR rounds in descending order, round keys from a local register store.
module inv_round_engine #(
   parameter int NR   = 10,
   parameter int KA_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            KEY_WR_EN,
   input  logic [KA_W-1:0] KEY_WR_ADDR,
   input  logic [127:0]    KEY_WR_DATA,
   input  logic            START,
   input  logic [127:0]    IN_DATA,
   output logic            BUSY,
   output logic            DONE,
   output logic [127:0]    OUT_DATA
);

   localparam int NK = 3 * NR;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t       state_q, state_d;
   logic [1:0]   phase_q, phase_d;
   logic [4:0]   rnd_q, rnd_d;
   logic [127:0] st_q, st_d;
   logic [127:0] out_q, out_d;
   logic [127:0] keys_q [NK];
   logic [127:0] k0, k1, k2;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a,
                                       input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = xt(t);
      end
      return p;
   endfunction

   // a^254 is the field inverse (and maps 0 to 0)
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] r;
      sq = a;
      r  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      logic [7:0] b;
      b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]}
        ^ {s[1:0], s[7:2]} ^ 8'h05;
      return ginv(b);
   endfunction

   function automatic logic [127:0] inv_sub(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++)
         r[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
      return r;
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [7:0]   a [4];
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int j = 0; j < 4; j++)
            a[j] = s[127-8*(4*c+j) -: 8];
         r[127-32*c -: 8] = gmul(a[0], 8'h0e) ^ gmul(a[1], 8'h0b)
                          ^ gmul(a[2], 8'h0d) ^ gmul(a[3], 8'h09);
         r[119-32*c -: 8] = gmul(a[0], 8'h09) ^ gmul(a[1], 8'h0e)
                          ^ gmul(a[2], 8'h0b) ^ gmul(a[3], 8'h0d);
         r[111-32*c -: 8] = gmul(a[0], 8'h0d) ^ gmul(a[1], 8'h09)
                          ^ gmul(a[2], 8'h0e) ^ gmul(a[3], 8'h0b);
         r[103-32*c -: 8] = gmul(a[0], 8'h0b) ^ gmul(a[1], 8'h0d)
                          ^ gmul(a[2], 8'h09) ^ gmul(a[3], 8'h0e);
      end
      return r;
   endfunction

   // row r of column c comes from column (c - r) mod 4
   function automatic logic [127:0] inv_shift(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++)
         for (int w = 0; w < 4; w++)
            r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+4-w)%4)+w) -: 8];
      return r;
   endfunction

   function automatic logic [127:0] sub_bytes_k(input logic [127:0] s,
                                                input logic [127:0] k);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++)
         r[127-8*i -: 8] = s[127-8*i -: 8] - k[127-8*i -: 8];
      return r;
   endfunction

   always_comb begin
      k0 = '0;
      k1 = '0;
      k2 = '0;
      for (int i = 0; i < NR; i++) begin
         if (rnd_q == 5'(i + 1)) begin
            k0 = keys_q[3*i];
            k1 = keys_q[3*i+1];
            k2 = keys_q[3*i+2];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int e = 0; e < NK; e++) keys_q[e] <= '0;
      end else if (KEY_WR_EN && state_q != RUN) begin
         for (int e = 0; e < NK; e++)
            if (KEY_WR_ADDR == KA_W'(e)) keys_q[e] <= KEY_WR_DATA;
      end
   end

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      rnd_d   = rnd_q;
      st_d    = st_q;
      out_d   = out_q;
      unique case (state_q)
         IDLE: begin
            if (START) begin
               st_d    = IN_DATA;
               rnd_d   = 5'(NR);
               phase_d = 2'd0;
               state_d = RUN;
            end
         end
         RUN: begin
            unique case (phase_q)
               2'd0: begin
                  st_d    = inv_mix(st_q ^ k2);
                  phase_d = 2'd1;
               end
               2'd1: begin
                  st_d    = inv_shift(sub_bytes_k(st_q, k1));
                  phase_d = 2'd2;
               end
               default: begin
                  st_d    = inv_sub(st_q ^ k0);
                  phase_d = 2'd0;
                  if (rnd_q == 5'd1) begin
                     out_d   = st_d;
                     state_d = FIN;
                  end else begin
                     rnd_d = rnd_q - 5'd1;
                  end
               end
            endcase
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         phase_q <= 2'd0;
         rnd_q   <= 5'd0;
         st_q    <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         rnd_q   <= rnd_d;
         st_q    <= st_d;
         out_q   <= out_d;
      end
   end

   assign BUSY     = (state_q == RUN);
   assign DONE     = (state_q == FIN);
   assign OUT_DATA = out_q;

endmodule

// File: tb/tb_inv_round_engine.sv
// Bench for inv_round_engine: NR=10 and NR=1 instances checked against a
// forward-round reference model (decrypt(encrypt(p)) must return p).
module tb_inv_round_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n = 1'b1;

   logic         we10, st10, busy10, done10;
   logic [5:0]   wa10;
   logic [127:0] wd10, in10, out10;
   logic         we1, st1, busy1, done1;
   logic [5:0]   wa1;
   logic [127:0] wd1, in1, out1;

   inv_round_engine #(.NR(10), .KA_W(6)) d10 (
      .clk(clk), .rst_n(rst_n),
      .KEY_WR_EN(we10), .KEY_WR_ADDR(wa10), .KEY_WR_DATA(wd10),
      .START(st10), .IN_DATA(in10),
      .BUSY(busy10), .DONE(done10), .OUT_DATA(out10));

   inv_round_engine #(.NR(1), .KA_W(6)) d1 (
      .clk(clk), .rst_n(rst_n),
      .KEY_WR_EN(we1), .KEY_WR_ADDR(wa1), .KEY_WR_DATA(wd1),
      .START(st1), .IN_DATA(in1),
      .BUSY(busy1), .DONE(done1), .OUT_DATA(out1));

   int total = 0;
   int bad = 0;
   logic [7:0] sbox [256];

   typedef struct {
      logic [127:0] k0, k1, k2, din, exp;
   } vec_t;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] r128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, t;
      p = 0;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv;
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3)
                 ^ rl(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] enc_round(input logic [127:0] d,
      input logic [127:0] k0, input logic [127:0] k1, input logic [127:0] k2);
      logic [7:0] x [16];
      logic [7:0] s [16];
      logic [7:0] m [16];
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++)
         x[i] = sbox[d[127-8*i -: 8]] ^ k0[127-8*i -: 8];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            s[4*c+r] = x[4*((c+r)%4)+r];
      for (int i = 0; i < 16; i++)
         m[i] = s[i] + k1[127-8*i -: 8];
      for (int c = 0; c < 4; c++) begin
         logic [7:0] a0, a1, a2, a3;
         a0 = m[4*c]; a1 = m[4*c+1]; a2 = m[4*c+2]; a3 = m[4*c+3];
         o[127-32*c -: 8] = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
         o[103-32*c -: 8] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
      end
      return o ^ k2;
   endfunction

   function automatic logic [127:0] enc10(input logic [127:0] pt,
                                          input logic [127:0] ks [30]);
      logic [127:0] d;
      d = pt;
      for (int r = 0; r < 10; r++)
         d = enc_round(d, ks[3*r], ks[3*r+1], ks[3*r+2]);
      return d;
   endfunction

   task automatic wr1(input logic [5:0] a, input logic [127:0] d);
      we1 = 1; wa1 = a; wd1 = d;
      @(negedge clk);
      we1 = 0;
   endtask

   task automatic wr10(input logic [5:0] a, input logic [127:0] d);
      we10 = 1; wa10 = a; wd10 = d;
      @(negedge clk);
      we10 = 0;
   endtask

   task automatic run1(input logic [127:0] din, output logic [127:0] res,
                       output int lat);
      st1 = 1; in1 = din;
      @(negedge clk);
      st1 = 0; we1 = 0; lat = 0;
      while (!done1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      res = out1;
   endtask

   task automatic run10(input logic [127:0] din, output logic [127:0] res,
                        output int lat, output int berr);
      st10 = 1; in10 = din;
      @(negedge clk);
      st10 = 0; lat = 0; berr = 0;
      while (!done10 && lat < 200) begin
         if (!busy10) berr++;
         @(negedge clk);
         lat++;
      end
      if (busy10) berr++;
      res = out10;
   endtask

   vec_t vt [8];
   logic [127:0] key10 [30];
   logic [127:0] zk [30];

   initial begin
      logic [127:0] res, pt, ct;
      int lat, berr, ndone, quiet;
      we10 = 0; st10 = 0; wa10 = 0; wd10 = 0; in10 = 0;
      we1 = 0; st1 = 0; wa1 = 0; wd1 = 0; in1 = 0;
      build_sbox();
      #2 rst_n = 0;
      repeat (2) @(negedge clk);
      chk("rst_busy10", 128'(busy10), 0);
      chk("rst_done10", 128'(done10), 0);
      chk("rst_out10", out10, 0);
      chk("rst_busy1", 128'(busy1), 0);
      chk("rst_done1", 128'(done1), 0);
      chk("rst_out1", out1, 0);
      rst_n = 1;
      quiet = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy10 || done10 || out10 != 0) quiet++;
         if (busy1 || done1 || out1 != 0) quiet++;
      end
      chk("idle_quiet", 128'(quiet), 0);

      vt[0] = '{0, 0, 0, 0, {16{8'h52}}};
      vt[1] = '{0, {16{8'h01}}, 0, 0, {16{8'h7d}}};
      vt[2] = '{0, 0, {16{8'h01}}, 0, {16{8'h09}}};
      vt[3] = '{{16{8'hff}}, 0, 0, 0, {16{8'h7d}}};
      for (int i = 4; i < 8; i++) begin
         vt[i].k0 = r128(); vt[i].k1 = r128(); vt[i].k2 = r128();
         vt[i].exp = r128();
         vt[i].din = enc_round(vt[i].exp, vt[i].k0, vt[i].k1, vt[i].k2);
      end
      for (int i = 0; i < 8; i++) begin
         wr1(0, vt[i].k0);
         wr1(1, vt[i].k1);
         wr1(2, vt[i].k2);
         run1(vt[i].din, res, lat);
         chk($sformatf("vec%0d_out", i), res, vt[i].exp);
         chk($sformatf("vec%0d_lat", i), 128'(lat), 3);
         @(negedge clk);
      end

      wr1(0, 0); wr1(1, 0); wr1(2, 0);
      wr1(3, {16{8'hff}});
      run1(0, res, lat);
      chk("oor_write", res, {16{8'h52}});
      @(negedge clk);
      we1 = 1; wa1 = 1; wd1 = {16{8'h01}};
      run1(0, res, lat);
      chk("start_with_write", res, {16{8'h7d}});
      @(negedge clk);

      for (int i = 0; i < 30; i++) begin
         key10[i] = r128();
         zk[i] = '0;
         wr10(6'(i), key10[i]);
      end
      pt = 128'h00112233_44556677_8899aabb_ccddeeff;
      ct = enc10(pt, key10);
      run10(ct, res, lat, berr);
      chk("rt_out", res, pt);
      chk("rt_lat", 128'(lat), 30);
      chk("rt_busy", 128'(berr), 0);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         logic [127:0] p;
         p = r128();
         run10(enc10(p, key10), res, lat, berr);
         chk($sformatf("rand%0d_out", i), res, p);
         @(negedge clk);
      end

      st10 = 1; in10 = ct;
      @(negedge clk);
      st10 = 0;
      repeat (5) @(negedge clk);
      st10 = 1; in10 = r128();
      we10 = 1; wa10 = 0; wd10 = r128();
      @(negedge clk);
      st10 = 0; we10 = 0;
      ndone = 0; res = 0;
      for (int i = 0; i < 60; i++) begin
         if (done10) begin
            ndone++;
            res = out10;
         end
         @(negedge clk);
      end
      chk("blk_ndone", 128'(ndone), 1);
      chk("blk_out", res, pt);
      run10(ct, res, lat, berr);
      chk("blk_key0_kept", res, pt);
      @(negedge clk);

      st10 = 1; in10 = ct;
      @(negedge clk);
      st10 = 0;
      repeat (11) @(negedge clk);
      rst_n = 0;
      #1;
      chk("mid_rst_busy", 128'(busy10), 0);
      chk("mid_rst_done", 128'(done10), 0);
      chk("mid_rst_out10", out10, 0);
      chk("mid_rst_out1", out1, 0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      run1(0, res, lat);
      chk("post_rst_out1", res, {16{8'h52}});
      chk("post_rst_lat1", 128'(lat), 3);
      pt = r128();
      run10(enc10(pt, zk), res, lat, berr);
      chk("post_rst_out10", res, pt);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
